// File: rtl/mips_io_pkg.sv
// rtl/mips_io_pkg.sv - shared I/O register map constants for the MIPS I/O window
package mips_io_pkg;

    localparam logic [1:0]  IO_LED  = 2'd0;
    localparam logic [1:0]  IO_SW   = 2'd1;
    localparam logic [1:0]  IO_CNT  = 2'd2;
    localparam logic [1:0]  IO_BTN  = 2'd3;

    // Upper address bits the core's IsIO decode matches to route accesses here.
    localparam logic [27:0] IO_BASE = 28'h00007ff;

endpackage

// File: rtl/io_edge_sync.sv
// rtl/io_edge_sync.sv - 2-flop synchronizer with history flop for rising-edge detect
module io_edge_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] hist_q, hist_d;
    logic [2:0]   vld_q,  vld_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        hist_d = sync_q;
        vld_d  = {vld_q[1:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
            vld_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
            vld_q  <= vld_d;
        end
    end

    // Until hist holds a real sample, a high level left over from reset is not an edge.
    assign sync = sync_q;
    assign rise = sync_q & ~hist_q & {W{vld_q[2]}};

endmodule

// File: rtl/mips_io_responder.sv
// rtl/mips_io_responder.sv - memory-mapped LED/switch/counter/button responder for the MIPS core
module mips_io_responder
    import mips_io_pkg::*;
#(
    parameter int LED_W = 8,
    parameter int SW_W  = 8,
    parameter int BTN_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       IOAddr,
    input  logic [31:0]      IOWriteData,
    input  logic             IOWriteEn,
    output logic [31:0]      IOReadData,
    input  logic [SW_W-1:0]  Switches,
    input  logic [BTN_W-1:0] Buttons,
    output logic [LED_W-1:0] Leds
);

    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [BTN_W-1:0] btn_q, btn_d;

    logic [SW_W-1:0]  sw_sync;
    logic [SW_W-1:0]  sw_rise;
    logic [BTN_W-1:0] btn_sync;
    logic [BTN_W-1:0] btn_rise;
    logic             unused_bits;

    io_edge_sync #(.W(SW_W)) u_sw_sync (
        .clk  (CLK),
        .rst  (RESET),
        .din  (Switches),
        .sync (sw_sync),
        .rise (sw_rise)
    );

    io_edge_sync #(.W(BTN_W)) u_btn_sync (
        .clk  (CLK),
        .rst  (RESET),
        .din  (Buttons),
        .sync (btn_sync),
        .rise (btn_rise)
    );

    assign unused_bits = ^{IOAddr[1:0], sw_rise, btn_sync};

    always_comb begin
        led_d = led_q;
        cnt_d = cnt_q + 32'd1;
        btn_d = btn_q;
        if (IOWriteEn) begin
            case (IOAddr[3:2])
                IO_LED:  led_d = IOWriteData[LED_W-1:0];
                IO_CNT:  cnt_d = '0;
                IO_BTN:  btn_d = btn_q & ~IOWriteData[BTN_W-1:0];
                default: ;
            endcase
        end
        // A new press overrides a clear landing on the same edge.
        btn_d = btn_d | btn_rise;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            led_q <= '0;
            cnt_q <= '0;
            btn_q <= '0;
        end else begin
            led_q <= led_d;
            cnt_q <= cnt_d;
            btn_q <= btn_d;
        end
    end

    always_comb begin
        IOReadData = '0;
        case (IOAddr[3:2])
            IO_LED:  IOReadData = 32'(led_q);
            IO_SW:   IOReadData = 32'(sw_sync);
            IO_CNT:  IOReadData = cnt_q;
            IO_BTN:  IOReadData = 32'(btn_q);
            default: IOReadData = '0;
        endcase
    end

    assign Leds = led_q;

endmodule

// File: tb/tb_mips_io_responder.sv
// tb/tb_mips_io_responder.sv - scoreboard bench for mips_io_responder
module tb_mips_io_responder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [3:0]  IOAddr = '0;
    logic [31:0] IOWriteData = '0;
    logic        IOWriteEn = 1'b0;
    logic [31:0] IOReadData;
    logic [7:0]  Switches = '0;
    logic [3:0]  Buttons = '0;
    logic [7:0]  Leds;

    always #5 CLK = ~CLK;

    mips_io_responder #(.LED_W(8), .SW_W(8), .BTN_W(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IOAddr      (IOAddr),
        .IOWriteData (IOWriteData),
        .IOWriteEn   (IOWriteEn),
        .IOReadData  (IOReadData),
        .Switches    (Switches),
        .Buttons     (Buttons),
        .Leds        (Leds)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] rd;
        logic [7:0]  led;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   miscompares = 0;

    // Reference state: samples taken at each edge since the last reset.
    logic [7:0]  m_led = '0;
    logic [31:0] m_cnt = '0;
    logic [3:0]  m_btn = '0;
    logic [7:0]  sw_s[$];
    logic [3:0]  bt_s[$];
    bit          m_known = 0;

    function automatic logic [31:0] m_read(input logic [3:0] a);
        int n = sw_s.size();
        case (a[3:2])
            2'd0: return {24'd0, m_led};
            2'd1: return (n >= 2) ? {24'd0, sw_s[n-2]} : 32'd0;
            2'd2: return m_cnt;
            default: return {28'd0, m_btn};
        endcase
    endfunction

    task automatic cycle(input bit rst, input logic [3:0] a, input bit we,
                         input logic [31:0] wd, input logic [7:0] sw,
                         input logic [3:0] bt, input bit frc = 0);
        int n;
        logic [3:0] nb;
        @(negedge CLK);
        #1;
        RESET = rst; IOAddr = a; IOWriteEn = we; IOWriteData = wd;
        Switches = sw; Buttons = bt;
        if (frc) begin
            force dut.cnt_q = 32'hFFFF_FFFF;
            #1;
            release dut.cnt_q;
            m_cnt = 32'hFFFF_FFFF;
        end
        if (m_known) exp_q.push_back('{a, m_read(a), m_led});
        @(posedge CLK);
        if (rst) begin
            m_led = '0; m_cnt = '0; m_btn = '0;
            sw_s.delete(); bt_s.delete();
            m_known = 1;
        end else begin
            sw_s.push_back(sw);
            bt_s.push_back(bt);
            n = bt_s.size();
            nb = m_btn;
            if (we && a[3:2] == 2'd3) nb = nb & ~wd[3:0];
            if (n >= 4) nb = nb | (bt_s[n-3] & ~bt_s[n-4]);
            m_btn = nb;
            if (we && a[3:2] == 2'd0) m_led = wd[7:0];
            if (we && a[3:2] == 2'd2) m_cnt = '0;
            else m_cnt = m_cnt + 32'd1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vecs++;
                if (IOReadData !== e.rd) begin
                    miscompares++;
                    $display("FAIL rdata addr=%h got %h expected %h", e.addr, IOReadData, e.rd);
                end
                vecs++;
                if (Leds !== e.led) begin
                    miscompares++;
                    $display("FAIL leds got %h expected %h", Leds, e.led);
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] sw;
        logic [3:0] bt;
        int budget;

        // Reset with switches set, then reads of LED, BTN and the counter.
        cycle(1, 4'h0, 0, 0, 8'hA5, 4'h0);
        cycle(1, 4'h0, 0, 0, 8'hA5, 4'h0);
        cycle(0, 4'h8, 0, 0, 8'hA5, 4'h0);
        cycle(0, 4'h8, 0, 0, 8'hA5, 4'h0);
        cycle(0, 4'h0, 0, 0, 8'hA5, 4'h0);
        cycle(0, 4'hC, 0, 0, 8'hA5, 4'h0);

        // LED write/read, write to read-only SW.
        cycle(0, 4'h0, 1, 32'h1234_56C3, 8'hA5, 4'h0);
        cycle(0, 4'h0, 0, 0, 8'hA5, 4'h0);
        cycle(0, 4'h4, 1, 32'hFF, 8'hA5, 4'h0);
        cycle(0, 4'h5, 0, 0, 8'hA5, 4'h0);

        // Switch synchronizer latency.
        for (int i = 0; i < 4; i++) cycle(0, 4'h4, 0, 0, 8'h00, 4'h0);
        for (int i = 0; i < 4; i++) cycle(0, 4'h4, 0, 0, 8'h5A, 4'h0);

        // Counter after reset and 100 idle cycles, wrap, clear.
        cycle(1, 4'h8, 0, 0, 8'h00, 4'h0);
        for (int i = 0; i < 101; i++) cycle(0, 4'h8, 0, 0, 8'h00, 4'h0);
        cycle(0, 4'h8, 0, 0, 8'h00, 4'h0, 1);
        cycle(0, 4'h8, 0, 0, 8'h00, 4'h0);
        cycle(0, 4'h8, 0, 0, 8'h00, 4'h0);
        cycle(0, 4'hA, 1, 32'hDEAD_BEEF, 8'h00, 4'h0);
        cycle(0, 4'h8, 0, 0, 8'h00, 4'h0);

        // Button pulse on bit 2, then W1C of an idle bit and of bit 2.
        for (int i = 0; i < 3; i++) cycle(0, 4'hC, 0, 0, 8'h00, 4'h4);
        for (int i = 0; i < 4; i++) cycle(0, 4'hC, 0, 0, 8'h00, 4'h0);
        cycle(0, 4'hC, 1, 32'h1, 8'h00, 4'h0);
        cycle(0, 4'hC, 0, 0, 8'h00, 4'h0);
        cycle(0, 4'hC, 1, 32'h4, 8'h00, 4'h0);
        cycle(0, 4'hC, 0, 0, 8'h00, 4'h0);

        // Clear of bit 1 on the same edge that sets it.
        cycle(0, 4'hC, 0, 0, 8'h00, 4'h2);
        cycle(0, 4'hC, 0, 0, 8'h00, 4'h2);
        cycle(0, 4'hC, 1, 32'h2, 8'h00, 4'h2);
        cycle(0, 4'hC, 0, 0, 8'h00, 4'h2);
        cycle(0, 4'hC, 0, 0, 8'h00, 4'h0);

        // Reset beats a simultaneous LED write; button held across reset.
        cycle(0, 4'h0, 1, 32'h77, 8'h00, 4'h8);
        cycle(1, 4'h0, 1, 32'hFF, 8'h00, 4'h8);
        for (int i = 0; i < 5; i++) cycle(0, 4'hC, 0, 0, 8'h00, 4'h8);
        cycle(0, 4'h0, 0, 0, 8'h00, 4'h0);

        // Randomized traffic.
        sw = 8'h3C;
        bt = 4'h0;
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  a;
            logic [31:0] wd;
            bit          we;
            bit          rst;
            if ($urandom_range(9) == 0) sw = 8'($urandom);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) bt[b] = ~bt[b];
            a   = 4'($urandom);
            we  = ($urandom_range(9) < 3);
            wd  = $urandom;
            rst = ($urandom_range(99) == 0);
            cycle(rst, a, we, wd, sw, bt);
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge CLK);
            budget++;
        end
        vecs++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
